picoblaze_io_hub: RTL
=====================

PICOBLAZE_IO_HUB -- requirements
Module: picoblaze_io_hub

Interface
REQ-001 The block SHALL have parameter N_IN, default 8, meaning the number of 8-bit input ports (legal range 1..16).
REQ-002 The block SHALL have parameter N_OUT, default 8, meaning the number of 8-bit output ports (legal range 1..16).
REQ-003 The block SHALL have parameter N_IRQ, default 4, meaning the number of interrupt sources (legal range 1..8).
REQ-004 The block SHALL have port sysclk, input, width 1, the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port sysreset, input, width 1, the reset; it is asynchronous and active-low.
REQ-006 The block SHALL have port port_id, input, width 8, the PicoBlaze I/O address.
REQ-007 The block SHALL have ports write_strobe and read_strobe, input, width 1 each, the PicoBlaze access qualifiers.
REQ-008 The block SHALL have port io_data_in, input, width 8, the write data from PicoBlaze.
REQ-009 The block SHALL have port io_data_out, output, width 8, the registered read data to PicoBlaze.
REQ-010 The block SHALL have port interrupt_ack, input, width 1, the PicoBlaze interrupt acknowledge.
REQ-011 The block SHALL have port interrupt, output, width 1, the interrupt request to PicoBlaze.
REQ-012 The block SHALL have port in_ports, input, width 8*N_IN, where byte k is input port k.
REQ-013 The block SHALL have port out_ports, output, width 8*N_OUT, where byte k is output register k.
REQ-014 The block SHALL have port out_wr_pulse, output, width N_OUT, where bit k is a one-cycle strobe indicating that output port k was written.
REQ-015 The block SHALL have port irq_src, input, width N_IRQ, the asynchronous-domain-safe (already synchronous) event sources.

Function
REQ-016 The address map SHALL be: 0x00+k is input port k (R); 0x10+k is output port k (W); 0x20 is IRQ_PEND (R); 0x21 is IRQ_MASK (R/W); 0x22 is IRQ_CLR (W, write-1-to-clear).
REQ-017 Reads SHALL have one-cycle latency: io_data_out is registered from the port_id value in the previous cycle, independent of read_strobe.
REQ-018 A read of an unmapped address, an input k >= N_IN, or an unused upper IRQ bit SHALL return 0x00; the output SHALL never be X.
REQ-019 When write_strobe=1 and port_id=0x10+k (k<N_OUT), out_ports byte k SHALL update on that edge and out_wr_pulse[k] SHALL be high for exactly the following cycle.
REQ-020 Writes to unmapped addresses or to k>=N_OUT SHALL have no effect and SHALL produce no pulse.
REQ-021 Each irq_src bit SHALL be rising-edge detected against a registered copy; a detected edge SHALL set the corresponding IRQ_PEND bit on the same edge.
REQ-022 A write to IRQ_CLR SHALL clear the IRQ_PEND bits written as 1; if a new edge and a clear of the same bit coincide, the set SHALL win.
REQ-023 The interrupt controller SHALL have two states: ARMED and FIRED. In ARMED, if |(IRQ_PEND & IRQ_MASK) then interrupt<=1 and the state goes to FIRED. In FIRED, when (IRQ_PEND & IRQ_MASK)==0 the state goes to ARMED.
REQ-024 interrupt_ack=1 SHALL clear interrupt on that edge; if ack and arming coincide, ack SHALL take priority and interrupt SHALL re-assert no earlier than the next cycle.
REQ-025 Masked pending bits SHALL remain visible in IRQ_PEND and SHALL fire when they become unmasked while the controller is ARMED.

Reset
REQ-026 Asserting sysreset low SHALL immediately clear io_data_out, out_ports, out_wr_pulse, IRQ_PEND, IRQ_MASK, the edge registers, and interrupt, and SHALL put the controller in ARMED.
REQ-027 Reset asserted mid-access SHALL discard the access; release SHALL be synchronous to sysclk via the normal flop recovery, with no partial write retained.

Configuration
REQ-028 With macro IO_HUB_READBACK_EN defined, a read of 0x10+k (k<N_OUT) SHALL return out_ports byte k; without the macro, such a read SHALL return 0x00 and the readback multiplexer SHALL be absent.

Verification
REQ-029 Write 0x5A to 0x13 -> out_ports byte 3 = 0x5A and out_wr_pulse = 0x08 for exactly one cycle; all other bytes unchanged.
REQ-030 Read 0x02 with in_ports byte 2 = 0xC3 -> io_data_out = 0xC3 one cycle later; read 0x3F -> 0x00.
REQ-031 Set IRQ_MASK=0x01 and pulse irq_src[0] -> IRQ_PEND=0x01 and interrupt=1; ack -> interrupt=0; no re-assert until IRQ_CLR=0x01 is written and a new edge occurs.
REQ-032 Pulse irq_src[1] with IRQ_MASK=0x00 -> IRQ_PEND=0x02 and interrupt stays 0; write IRQ_MASK=0x02 -> interrupt=1.
REQ-033 Write IRQ_CLR=0x01 in the same cycle as an irq_src[0] edge -> IRQ_PEND[0] remains 1.
REQ-034 Assert sysreset low mid-write to 0x10 -> out_ports=0, interrupt=0, and the controller is ARMED; with IO_HUB_READBACK_EN, a read of 0x10 after a write of 0x77 -> 0x77.

Source files
------------

// File: rtl/picoblaze_io_hub.sv
// picoblaze_io_hub
// I/O hub for a PicoBlaze core. It provides input ports, output registers
// with write strobes, and a small maskable interrupt controller.
//
// Address map (port_id):
//   0x00+k  input port k        (R)
//   0x10+k  output register k   (W; R only with IO_HUB_READBACK_EN)
//   0x20    IRQ_PEND            (R)
//   0x21    IRQ_MASK            (R/W)
//   0x22    IRQ_CLR             (W, write-1-to-clear)
//
// Ports:
//   sysclk        system clock; all logic is on its rising edge
//   sysreset      asynchronous reset, active low
//   port_id       PicoBlaze I/O address
//   write_strobe  write qualifier
//   read_strobe   read qualifier (not needed: read data is registered every cycle)
//   io_data_in    write data from PicoBlaze
//   io_data_out   registered read data, one cycle after port_id
//   interrupt_ack interrupt acknowledge from PicoBlaze
//   interrupt     interrupt request to PicoBlaze
//   in_ports      N_IN input bytes; byte k is input port k
//   out_ports     N_OUT output bytes; byte k is output register k
//   out_wr_pulse  bit k is high for one cycle after output register k is written
//   irq_src       N_IRQ event sources, already synchronous to sysclk
//
// Build option:
//   IO_HUB_READBACK_EN  when defined, reads of 0x10+k return output register k.
//                       When undefined, those reads return 0x00 and the readback
//                       multiplexer is not built.
//
// Interrupt controller states:
//   state    | meaning
//   ST_ARMED | waiting for an unmasked pending bit; raises interrupt when one appears
//   ST_FIRED | interrupt raised; waits until no unmasked pending bit remains

module picoblaze_io_hub #(
  parameter int N_IN  = 8,
  parameter int N_OUT = 8,
  parameter int N_IRQ = 4
) (
  input  logic                 sysclk,
  input  logic                 sysreset,
  input  logic [7:0]           port_id,
  input  logic                 write_strobe,
  input  logic                 read_strobe,
  input  logic [7:0]           io_data_in,
  output logic [7:0]           io_data_out,
  input  logic                 interrupt_ack,
  output logic                 interrupt,
  input  logic [8*N_IN-1:0]    in_ports,
  output logic [8*N_OUT-1:0]   out_ports,
  output logic [N_OUT-1:0]     out_wr_pulse,
  input  logic [N_IRQ-1:0]     irq_src
);

  localparam logic [7:0] ADDR_OUT_BASE = 8'h10;
  localparam logic [7:0] ADDR_IRQ_PEND = 8'h20;
  localparam logic [7:0] ADDR_IRQ_MASK = 8'h21;
  localparam logic [7:0] ADDR_IRQ_CLR  = 8'h22;

  typedef enum logic {
    ST_ARMED = 1'b0,
    ST_FIRED = 1'b1
  } irq_state_t;

  irq_state_t          irq_state;
  logic [N_IRQ-1:0]    irq_pend;
  logic [N_IRQ-1:0]    irq_mask;
  logic [N_IRQ-1:0]    irq_src_q;
  logic [N_IRQ-1:0]    irq_edge;
  logic [N_IRQ-1:0]    irq_clr;
  logic                irq_active;

  logic [N_OUT-1:0]    wr_out_sel;
  logic                wr_mask;
  logic                wr_clr;
  logic [7:0]          rd_next;

  // Read data is registered from port_id every cycle, so the strobe carries
  // no information for this block.
  logic unused_read_strobe;
  assign unused_read_strobe = read_strobe;

  // ---------------------------------------------------------------------------
  // Write decode
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_out_sel = '0;
    for (int k = 0; k < N_OUT; k++) begin
      if (write_strobe && (port_id == ADDR_OUT_BASE + 8'(k))) begin
        wr_out_sel[k] = 1'b1;
      end
    end
  end

  assign wr_mask = write_strobe && (port_id == ADDR_IRQ_MASK);
  assign wr_clr  = write_strobe && (port_id == ADDR_IRQ_CLR);

  // ---------------------------------------------------------------------------
  // Read multiplexer; anything not decoded reads as 0x00
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_next = 8'h00;
    for (int k = 0; k < N_IN; k++) begin
      if (port_id == 8'(k)) begin
        rd_next = in_ports[8*k +: 8];
      end
    end
`ifdef IO_HUB_READBACK_EN
    for (int k = 0; k < N_OUT; k++) begin
      if (port_id == ADDR_OUT_BASE + 8'(k)) begin
        rd_next = out_ports[8*k +: 8];
      end
    end
`endif
    if (port_id == ADDR_IRQ_PEND) begin
      for (int i = 0; i < N_IRQ; i++) begin
        rd_next[i] = irq_pend[i];
      end
    end
    if (port_id == ADDR_IRQ_MASK) begin
      for (int i = 0; i < N_IRQ; i++) begin
        rd_next[i] = irq_mask[i];
      end
    end
  end

  always_ff @(posedge sysclk or negedge sysreset) begin
    if (!sysreset) begin
      io_data_out <= 8'h00;
    end else begin
      io_data_out <= rd_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers and write strobes
  // ---------------------------------------------------------------------------
  always_ff @(posedge sysclk or negedge sysreset) begin
    if (!sysreset) begin
      out_ports    <= '0;
      out_wr_pulse <= '0;
    end else begin
      out_wr_pulse <= wr_out_sel;
      for (int k = 0; k < N_OUT; k++) begin
        if (wr_out_sel[k]) begin
          out_ports[8*k +: 8] <= io_data_in;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupt sources: edge detect, pending and mask registers
  // ---------------------------------------------------------------------------
  assign irq_edge   = irq_src & ~irq_src_q;
  assign irq_clr    = wr_clr ? io_data_in[N_IRQ-1:0] : '0;
  assign irq_active = |(irq_pend & irq_mask);

  always_ff @(posedge sysclk or negedge sysreset) begin
    if (!sysreset) begin
      irq_src_q <= '0;
      irq_pend  <= '0;
      irq_mask  <= '0;
    end else begin
      irq_src_q <= irq_src;
      // Set is applied after clear so a new edge survives a coincident clear.
      irq_pend  <= (irq_pend & ~irq_clr) | irq_edge;
      if (wr_mask) begin
        irq_mask <= io_data_in[N_IRQ-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupt controller
  // ---------------------------------------------------------------------------
  // An ack that lands on the arming edge wins and keeps the controller ARMED,
  // so a still-pending source re-raises interrupt on the next cycle instead of
  // being lost.
  always_ff @(posedge sysclk or negedge sysreset) begin
    if (!sysreset) begin
      irq_state <= ST_ARMED;
      interrupt <= 1'b0;
    end else begin
      case (irq_state)
        ST_ARMED: begin
          if (interrupt_ack) begin
            interrupt <= 1'b0;
          end else if (irq_active) begin
            interrupt <= 1'b1;
            irq_state <= ST_FIRED;
          end
        end
        ST_FIRED: begin
          if (interrupt_ack) begin
            interrupt <= 1'b0;
          end
          if (!irq_active) begin
            irq_state <= ST_ARMED;
          end
        end
        default: begin
          irq_state <= ST_ARMED;
          interrupt <= 1'b0;
        end
      endcase
    end
  end

endmodule
